cpc_mem_arbiter: RTL and testbench
==================================

Name: cpc_mem_arbiter

Overview:
- Shares the single external memory port between three requesters: gate-array video fetch, Z80 CPU access, and the Plus-mode ASIC DMA (sound list) reader.
- Sits between the motherboard core and the SDRAM controller.
- Video is fixed highest priority. CPU outranks DMA. DMA has an anti-starvation promotion.
- One transaction is outstanding at a time, using a request/acknowledge handshake on each side.

Parameters:
- AW, 23, memory word address width (byte address for CPU).
- STARVE, 4, number of consecutive CPU grants after which a pending DMA request is promoted above CPU (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- vid_req  in  1  video fetch request, level, held until vid_ack
- vid_addr  in  15  video word address (maps to AW bits as {8'h00, vid_addr})
- vid_data  out  16  fetched video word
- vid_ack  out  1  one-cycle pulse, vid_data valid same cycle
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  8  CPU write byte
- cpu_rdata  out  8  CPU read byte
- cpu_ack  out  1  one-cycle completion pulse
- dma_req  in  1  DMA read request, level, held until dma_ack
- dma_addr  in  AW  DMA word address
- dma_data  out  16  DMA read word
- dma_ack  out  1  one-cycle pulse
- mem_req  out  1  one-cycle request strobe to memory controller
- mem_we  out  1  write enable qualifying mem_req
- mem_addr  out  AW  memory address
- mem_wdata  out  8  write byte
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse from controller
- busy  out  1  transaction outstanding

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; starvation counter = 0; owner = none.
- FSM states:
  - IDLE: sample requests. Priority is vid > (dma if promoted) > cpu > dma. A grant latches owner, address, we and wdata, then moves to ISSUE. No request: stay in IDLE.
  - ISSUE: assert mem_req for exactly one cycle with the latched fields, then go to WAIT.
  - WAIT: hold mem_addr/mem_we/mem_wdata stable. On mem_ack, route the result to the owner, pulse that owner's ack in the same cycle, then go to IDLE.
- Minimum latency: request seen in IDLE at cycle N, mem_req at N+1, ack at mem_ack cycle (≥ N+2). There is no back-to-back skip of IDLE, so every transaction takes at least 3 cycles.
- Read routing:
  - vid_data and dma_data are registered copies of mem_rdata, updated only on that owner's ack.
  - cpu_rdata = mem_rdata[15:8] when cpu_addr[0] = 1, else mem_rdata[7:0], using the latched address bit.
- CPU writes: mem_addr = cpu_addr, mem_we = 1, mem_wdata = cpu_wdata. Byte lane selection belongs to the controller.
- Starvation counter:
  - Increments on each CPU grant while dma_req = 1. Saturates at STARVE.
  - Clears on a DMA grant or when dma_req = 0.
  - When count == STARVE, DMA is promoted above CPU, never above video.
- Simultaneous events: requests arriving outside IDLE wait, and are evaluated at the next IDLE.
- A requester dropping req while it owns the transaction is a protocol violation. The transaction still completes and the ack still pulses.
- mem_ack outside WAIT is ignored.
- Reset asserted mid-transaction aborts immediately: no ack is generated, and outputs return to reset values.
- busy = 1 in ISSUE and WAIT.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds outputs stat_vid, stat_cpu, stat_dma (16 bits each). They count grants per requester, wrap at 16'hFFFF → 0, and are cleared by reset.
- Adds a 16-bit stat_maxwait register holding the longest CPU wait (cycles from cpu_req rising in IDLE/ISSUE/WAIT to cpu_ack), saturating at 16'hFFFF.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Single CPU read, cpu_addr=23'h000101, controller returns mem_rdata=16'hA55A two cycles after mem_req → mem_req one cycle at N+1, mem_addr=23'h000101, mem_we=0, cpu_ack pulse with cpu_rdata=8'hA5.
- vid_req, cpu_req and dma_req all asserted in the same cycle → grant order vid, cpu, dma; each ack a single pulse; vid_data latches the first mem_rdata.
- STARVE=4: cpu_req held continuously, dma_req held → four CPU grants, then DMA granted fifth, counter clears, CPU resumes.
- Video arriving during a CPU WAIT → CPU completes first; video is granted at the next IDLE ahead of a pending promoted DMA.
- Reset pulsed during WAIT of a CPU write → no cpu_ack, all outputs 0 next edge; a later mem_ack is ignored and the FSM stays in IDLE.
- With ARB_STATS_EN: 3 video, 2 CPU, 1 DMA transactions → stat_vid=3, stat_cpu=2, stat_dma=1.

Source files
------------

// File: rtl/cpc_mem_arbiter.sv
// Memory port arbiter for video fetch, Z80 CPU and Plus-mode DMA, one transaction at a time.
// Define ARB_STATS_EN to add per-requester grant counters and a worst-case CPU wait register.
module cpc_mem_arbiter #(
    parameter int unsigned AW     = 23,
    parameter int unsigned STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [14:0]   vid_addr,
    output logic [15:0]   vid_data,
    output logic          vid_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic [15:0]   dma_data,
    output logic          dma_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   stat_vid,
    output logic [15:0]   stat_cpu,
    output logic [15:0]   stat_dma,
    output logic [15:0]   stat_maxwait
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
    typedef enum logic [1:0] {OwnNone, OwnVid, OwnCpu, OwnDma} owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [15:0]   vid_data_q, vid_data_d;
    logic [15:0]   dma_data_q, dma_data_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [3:0]    starve_q, starve_d;
    logic          promoted;
    logic          grant_cpu;
    logic          grant_dma;
    logic [7:0]    cpu_byte;

    assign promoted = (starve_q == 4'(STARVE));
    assign cpu_byte = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        vid_data_d  = vid_data_q;
        dma_data_d  = dma_data_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_ack     = 1'b0;
        cpu_ack     = 1'b0;
        dma_ack     = 1'b0;
        mem_req     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (vid_req) begin
                    owner_d = OwnVid;
                    addr_d  = {{(AW-15){1'b0}}, vid_addr};
                    we_d    = 1'b0;
                    wdata_d = 8'h00;
                    state_d = StIssue;
                end else if (dma_req && promoted) begin
                    owner_d = OwnDma;
                    addr_d  = dma_addr;
                    we_d    = 1'b0;
                    wdata_d = 8'h00;
                    state_d = StIssue;
                end else if (cpu_req) begin
                    owner_d = OwnCpu;
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = StIssue;
                end else if (dma_req) begin
                    owner_d = OwnDma;
                    addr_d  = dma_addr;
                    we_d    = 1'b0;
                    wdata_d = 8'h00;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem_req = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (mem_ack) begin
                    state_d = StIdle;
                    owner_d = OwnNone;
                    unique case (owner_q)
                        OwnVid: begin
                            vid_ack    = 1'b1;
                            vid_data_d = mem_rdata;
                        end
                        OwnCpu: begin
                            cpu_ack     = 1'b1;
                            cpu_rdata_d = cpu_byte;
                        end
                        OwnDma: begin
                            dma_ack    = 1'b1;
                            dma_data_d = mem_rdata;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A grant is the only way owner leaves OwnNone while in StIdle.
    assign grant_cpu = (state_q == StIdle) && (owner_d == OwnCpu);
    assign grant_dma = (state_q == StIdle) && (owner_d == OwnDma);

    always_comb begin
        starve_d = starve_q;
        if (!dma_req || grant_dma) begin
            starve_d = 4'd0;
        end else if (grant_cpu && !promoted) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= OwnNone;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= 8'h00;
            vid_data_q  <= 16'h0000;
            dma_data_q  <= 16'h0000;
            cpu_rdata_q <= 8'h00;
            starve_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            vid_data_q  <= vid_data_d;
            dma_data_q  <= dma_data_d;
            cpu_rdata_q <= cpu_rdata_d;
            starve_q    <= starve_d;
        end
    end

    // Read data is valid in the ack cycle and held afterwards.
    assign vid_data  = vid_data_d;
    assign dma_data  = dma_data_d;
    assign cpu_rdata = cpu_rdata_d;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle);

`ifdef ARB_STATS_EN
    logic [15:0] stat_vid_q, stat_vid_d;
    logic [15:0] stat_cpu_q, stat_cpu_d;
    logic [15:0] stat_dma_q, stat_dma_d;
    logic [15:0] maxwait_q, maxwait_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        wait_act_q, wait_act_d;

    always_comb begin
        stat_vid_d = stat_vid_q;
        stat_cpu_d = stat_cpu_q;
        stat_dma_d = stat_dma_q;
        maxwait_d  = maxwait_q;
        wait_cnt_d = wait_cnt_q;
        wait_act_d = wait_act_q;
        if (state_q == StIdle) begin
            if (owner_d == OwnVid) stat_vid_d = stat_vid_q + 16'd1;
            if (owner_d == OwnCpu) stat_cpu_d = stat_cpu_q + 16'd1;
            if (owner_d == OwnDma) stat_dma_d = stat_dma_q + 16'd1;
        end
        // wait_cnt_q equals cycles elapsed since the request was first seen.
        if (wait_act_q) begin
            if (cpu_ack) begin
                wait_act_d = 1'b0;
                if (wait_cnt_q > maxwait_q) maxwait_d = wait_cnt_q;
            end else if (wait_cnt_q != 16'hFFFF) begin
                wait_cnt_d = wait_cnt_q + 16'd1;
            end
        end else if (cpu_req && !cpu_ack) begin
            wait_act_d = 1'b1;
            wait_cnt_d = 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_vid_q <= 16'h0000;
            stat_cpu_q <= 16'h0000;
            stat_dma_q <= 16'h0000;
            maxwait_q  <= 16'h0000;
            wait_cnt_q <= 16'h0000;
            wait_act_q <= 1'b0;
        end else begin
            stat_vid_q <= stat_vid_d;
            stat_cpu_q <= stat_cpu_d;
            stat_dma_q <= stat_dma_d;
            maxwait_q  <= maxwait_d;
            wait_cnt_q <= wait_cnt_d;
            wait_act_q <= wait_act_d;
        end
    end

    assign stat_vid     = stat_vid_q;
    assign stat_cpu     = stat_cpu_q;
    assign stat_dma     = stat_dma_q;
    assign stat_maxwait = maxwait_q;
`endif

endmodule

// File: tb/tb_cpc_mem_arbiter.sv
// Directed bench for cpc_mem_arbiter with a fixed-latency memory model (ack two cycles
// after mem_req) and auto-deasserting requesters.
module tb_cpc_mem_arbiter;
    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req, cpu_req, cpu_we, dma_req, mem_ack;
    logic [14:0]   vid_addr;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [7:0]    cpu_wdata, cpu_rdata, mem_wdata;
    logic [15:0]   vid_data, dma_data, mem_rdata;
    logic          vid_ack, cpu_ack, dma_ack, mem_req, mem_we, busy;
`ifdef ARB_STATS_EN
    logic [15:0]   stat_vid, stat_cpu, stat_dma, stat_maxwait;
`endif

    int            total = 0;
    int            bad = 0;
    int            ev_q[$];
    logic [15:0]   evd_q[$];
    logic [AW-1:0] ra_q[$];
    logic [15:0]   rd_q[$];
    int            pulse_err = 0;
    bit            hold_cpu = 1'b0;
    bit            drop_vid = 1'b0, drop_cpu = 1'b0, drop_dma = 1'b0;
    bit            mdl_on = 1'b1;
    int            mdl_cnt = 0;
    logic          pv = 1'b0, pc = 1'b0, pd = 1'b0;

    cpc_mem_arbiter #(.AW(AW), .STARVE(4)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(dma_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
`ifdef ARB_STATS_EN
        , .stat_vid(stat_vid), .stat_cpu(stat_cpu), .stat_dma(stat_dma),
        .stat_maxwait(stat_maxwait)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle mem_ack two cycles after the mem_req cycle.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mdl_on) begin
                mem_ack   = 1'b0;
                mem_rdata = 16'h0000;
                if (mdl_cnt > 0) begin
                    mdl_cnt--;
                    if (mdl_cnt == 0) begin
                        mem_ack   = 1'b1;
                        mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0000;
                    end
                end
                if (mem_req) mdl_cnt = 2;
            end
        end
    end

    // Event monitor: records acks, issued addresses and multi-cycle ack pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (vid_ack) begin
                ev_q.push_back(1); evd_q.push_back(vid_data); drop_vid = 1'b1;
                if (pv) pulse_err++;
            end
            if (cpu_ack) begin
                ev_q.push_back(2); evd_q.push_back({8'h00, cpu_rdata});
                if (!hold_cpu) drop_cpu = 1'b1;
                if (pc) pulse_err++;
            end
            if (dma_ack) begin
                ev_q.push_back(3); evd_q.push_back(dma_data); drop_dma = 1'b1;
                if (pd) pulse_err++;
            end
            if (mem_req) ra_q.push_back(mem_addr);
            pv = vid_ack; pc = cpu_ack; pd = dma_ack;
        end
    end

    // Requesters release their request the cycle after their ack.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (drop_vid) begin vid_req = 1'b0; drop_vid = 1'b0; end
            if (drop_cpu) begin cpu_req = 1'b0; drop_cpu = 1'b0; end
            if (drop_dma) begin dma_req = 1'b0; drop_dma = 1'b0; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; dma_req = 1'b0; dma_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        mdl_on = 1'b1; mdl_cnt = 0; hold_cpu = 1'b0;
        drop_vid = 1'b0; drop_cpu = 1'b0; drop_dma = 1'b0;
        ev_q.delete(); evd_q.delete(); ra_q.delete(); rd_q.delete(); pulse_err = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_events(input int n, input int budget, input string name);
        int c = 0;
        while (ev_q.size() < n && c < budget) begin smp(); c++; end
        total++;
        if (ev_q.size() < n) begin
            bad++; $display("FAIL %s: acks seen=%0d required=%0d", name, ev_q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        mdl_on = 1'b0;
        tick(); mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        smp();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b want=0", busy); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mreq: got=%b want=0", mem_req); end
        total++; if ({vid_ack, cpu_ack, dma_ack} !== 3'b000) begin
            bad++; $display("FAIL rst_acks: got=%b want=000", {vid_ack, cpu_ack, dma_ack});
        end
        total++; if (mem_addr !== '0 || mem_we !== 1'b0 || mem_wdata !== 8'h00) begin
            bad++; $display("FAIL rst_mem: got=%h/%b/%h want=0/0/0", mem_addr, mem_we, mem_wdata);
        end
        total++; if (vid_data !== 16'h0 || dma_data !== 16'h0 || cpu_rdata !== 8'h0) begin
            bad++; $display("FAIL rst_data: got=%h/%h/%h want=0/0/0", vid_data, dma_data, cpu_rdata);
        end
        tick(); mem_ack = 1'b0; mem_rdata = 16'h0;
        smp();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stray_ack_busy: got=%b want=0", busy); end
    endtask

    task automatic test_cpu_read();
        do_reset();
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000101; rd_q.push_back(16'hA55A);
        smp();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rd_n_mreq: got=%b want=0", mem_req); end
        tick(); smp();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rd_n1_mreq: got=%b want=1", mem_req); end
        total++; if (mem_addr !== 23'h000101) begin
            bad++; $display("FAIL rd_addr: got=%h want=000101", mem_addr);
        end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_we: got=%b want=0", mem_we); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rd_busy: got=%b want=1", busy); end
        tick(); smp();
        total++; if (mem_req !== 1'b0 || cpu_ack !== 1'b0) begin
            bad++; $display("FAIL rd_n2: got mreq=%b ack=%b want 0/0", mem_req, cpu_ack);
        end
        tick(); smp();
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL rd_ack: got=%b want=1", cpu_ack); end
        total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("FAIL rd_data: got=%h want=a5", cpu_rdata); end
        tick(); smp();
        total++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rd_after: got ack=%b busy=%b want 0/0", cpu_ack, busy);
        end
        tick(); smp();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_nore: got=%b want=0", busy); end
    endtask

    task automatic test_all_three();
        do_reset();
        tick();
        vid_req = 1'b1; vid_addr = 15'h1234;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000200;
        dma_req = 1'b1; dma_addr = 23'h0ABCDE;
        rd_q.push_back(16'h1111); rd_q.push_back(16'h2222); rd_q.push_back(16'h3333);
        wait_events(3, 60, "all3_wait");
        repeat (3) smp();
        total++; if (ev_q.size() != 3) begin bad++; $display("FAIL all3_count: got=%0d want=3", ev_q.size()); end
        total++; if (ev_q[0] != 1 || ev_q[1] != 2 || ev_q[2] != 3) begin
            bad++; $display("FAIL all3_order: got=%0d,%0d,%0d want=1,2,3", ev_q[0], ev_q[1], ev_q[2]);
        end
        total++; if (ra_q[0] !== 23'h001234 || ra_q[2] !== 23'h0ABCDE) begin
            bad++; $display("FAIL all3_addr: got=%h,%h want=001234,0abcde", ra_q[0], ra_q[2]);
        end
        total++; if (evd_q[1] !== 16'h0022 || evd_q[2] !== 16'h3333) begin
            bad++; $display("FAIL all3_rdata: got=%h,%h want=0022,3333", evd_q[1], evd_q[2]);
        end
        total++; if (vid_data !== 16'h1111) begin bad++; $display("FAIL all3_vdata: got=%h want=1111", vid_data); end
        total++; if (pulse_err != 0) begin bad++; $display("FAIL all3_pulse: got=%0d want=0", pulse_err); end
    endtask

    task automatic test_starve();
        do_reset();
        hold_cpu = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_addr = 23'h000010; dma_req = 1'b1; dma_addr = 23'h000300;
        wait_events(6, 80, "stv_wait");
        tick(); cpu_req = 1'b0;
        total++; if (ev_q[0] != 2 || ev_q[1] != 2 || ev_q[2] != 2 || ev_q[3] != 2) begin
            bad++; $display("FAIL stv_cpu4: got=%0d,%0d,%0d,%0d want=2,2,2,2",
                            ev_q[0], ev_q[1], ev_q[2], ev_q[3]);
        end
        total++; if (ev_q[4] != 3) begin bad++; $display("FAIL stv_dma5: got=%0d want=3", ev_q[4]); end
        total++; if (ev_q[5] != 2) begin bad++; $display("FAIL stv_resume: got=%0d want=2", ev_q[5]); end
        total++; if (ra_q[4] !== 23'h000300) begin bad++; $display("FAIL stv_addr: got=%h want=000300", ra_q[4]); end
    endtask

    task automatic test_vid_during_wait();
        int c = 0;
        do_reset();
        hold_cpu = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_addr = 23'h000020; dma_req = 1'b1; dma_addr = 23'h000300;
        wait_events(3, 60, "vw_wait3");
        while (mem_req !== 1'b1 && c < 20) begin smp(); c++; end
        total++; if (mem_addr !== 23'h000020) begin
            bad++; $display("FAIL vw_cpu4_issue: got=%h want=000020", mem_addr);
        end
        tick(); vid_req = 1'b1; vid_addr = 15'h0042;
        smp();
        total++; if (busy !== 1'b1 || vid_ack !== 1'b0) begin
            bad++; $display("FAIL vw_inwait: got busy=%b vack=%b want 1/0", busy, vid_ack);
        end
        wait_events(6, 60, "vw_wait6");
        tick(); cpu_req = 1'b0;
        total++; if (ev_q[3] != 2 || ev_q[4] != 1 || ev_q[5] != 3) begin
            bad++; $display("FAIL vw_order: got=%0d,%0d,%0d want=2,1,3", ev_q[3], ev_q[4], ev_q[5]);
        end
        total++; if (ra_q[4] !== 23'h000042 || ra_q[5] !== 23'h000300) begin
            bad++; $display("FAIL vw_addr: got=%h,%h want=000042,000300", ra_q[4], ra_q[5]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mdl_on = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h012345; cpu_wdata = 8'h3C;
        tick(); smp();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 8'h3C) begin
            bad++; $display("FAIL wr_issue: got=%b/%b/%h want=1/1/3c", mem_req, mem_we, mem_wdata);
        end
        total++; if (mem_addr !== 23'h012345) begin bad++; $display("FAIL wr_addr: got=%h want=012345", mem_addr); end
        tick(); smp();
        total++; if (busy !== 1'b1 || mem_we !== 1'b1) begin
            bad++; $display("FAIL wr_wait: got busy=%b we=%b want 1/1", busy, mem_we);
        end
        reset = 1'b1; #1;
        total++; if (busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 8'h0) begin
            bad++; $display("FAIL abort_outs: got=%b/%b/%h/%h want=0/0/0/0", busy, mem_we, mem_addr, mem_wdata);
        end
        tick(); reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        smp();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got=%b want=0", busy); end
        tick(); mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        smp();
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL late_ack: got=%b want=0", cpu_ack); end
        tick(); mem_ack = 1'b0;
        smp();
        total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL late_idle: got mreq=%b busy=%b want 0/0", mem_req, busy);
        end
        total++; if (ev_q.size() != 0) begin bad++; $display("FAIL abort_noack: got=%0d want=0", ev_q.size()); end
    endtask

`ifdef ARB_STATS_EN
    task automatic do_one(input int kind);
        tick();
        if (kind == 1) begin vid_req = 1'b1; vid_addr = 15'h0007; end
        if (kind == 2) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000044; end
        if (kind == 3) begin dma_req = 1'b1; dma_addr = 23'h000500; end
        wait_events(ev_q.size() + 1, 20, "stat_txn");
        tick(); tick();
    endtask

    task automatic test_stats();
        do_reset();
        do_one(1); do_one(2); do_one(1); do_one(3); do_one(2); do_one(1);
        smp();
        total++; if (stat_vid !== 16'd3) begin bad++; $display("FAIL stat_vid: got=%0d want=3", stat_vid); end
        total++; if (stat_cpu !== 16'd2) begin bad++; $display("FAIL stat_cpu: got=%0d want=2", stat_cpu); end
        total++; if (stat_dma !== 16'd1) begin bad++; $display("FAIL stat_dma: got=%0d want=1", stat_dma); end
        total++; if (stat_maxwait !== 16'd3) begin
            bad++; $display("FAIL stat_maxwait: got=%0d want=3", stat_maxwait);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        test_reset();
        test_cpu_read();
        test_all_three();
        test_starve();
        test_vid_during_wait();
        test_reset_mid();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
